serv_pwr_ctrl: RTL

Responder for the core's sleep/wakeup request pair. Accepts the core's WFI sleep request, waits for the bus to go idle, and drops the clock-gate enable. On a wakeup request it waits a programmable settle delay, then re-enables the core clock and pulses an acknowledge so the core retires the WFI. Sits in the always-on clock domain between the core and the integrated clock-gating cell.

---
 rtl/serv_pwr_ctrl_if.sv | 33 +++
 rtl/serv_pwr_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serv_pwr_ctrl_if.sv
// rtl/serv_pwr_ctrl_if.sv - core-side sleep/wakeup handshake bundle for serv_pwr_ctrl (stats signals under SERV_PWR_STATS_EN)
interface serv_pwr_ctrl_if;
  logic        i_sleep_req;
  logic        i_wakeup_req;
  logic        i_bus_idle;
  logic        o_clk_en;
  logic        o_sleeping;
  logic        o_wake_ack;
`ifdef SERV_PWR_STATS_EN
  logic        i_stats_clr;
  logic [31:0] o_sleep_cycles;
`endif

`ifdef SERV_PWR_STATS_EN
  modport master (
    output i_sleep_req, i_wakeup_req, i_bus_idle, i_stats_clr,
    input  o_clk_en, o_sleeping, o_wake_ack, o_sleep_cycles
  );
  modport slave (
    input  i_sleep_req, i_wakeup_req, i_bus_idle, i_stats_clr,
    output o_clk_en, o_sleeping, o_wake_ack, o_sleep_cycles
  );
`else
  modport master (
    output i_sleep_req, i_wakeup_req, i_bus_idle,
    input  o_clk_en, o_sleeping, o_wake_ack
  );
  modport slave (
    input  i_sleep_req, i_wakeup_req, i_bus_idle,
    output o_clk_en, o_sleeping, o_wake_ack
  );
`endif
endinterface

// File: rtl/serv_pwr_ctrl.sv
// rtl/serv_pwr_ctrl.sv - WFI sleep/wakeup responder driving the core clock-gate enable
// Optional gated-cycle counter enabled by defining SERV_PWR_STATS_EN.
module serv_pwr_ctrl #(
  parameter int unsigned WAKE_DELAY  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  serv_pwr_ctrl_if.slave pwr
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       clk_en_q, clk_en_d;
  logic       sleeping_q, sleeping_d;
  logic       wake_ack_q, wake_ack_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wk;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign wk = pwr.i_wakeup_req;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d = SYNC_STAGES'({sync_q, pwr.i_wakeup_req});
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= sync_d;
      end

      assign wk = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    clk_en_d   = clk_en_q;
    sleeping_d = sleeping_q;
    wake_ack_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        // The ack cycle itself is a holdoff so the core can drop its request.
        if (pwr.i_sleep_req && !wake_ack_q) begin
          if (wk) wake_ack_d = 1'b1;
          else    state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wk) begin
          state_d    = ST_RUN;
          wake_ack_d = 1'b1;
        end else if (!pwr.i_sleep_req) begin
          state_d = ST_RUN;
        end else if (pwr.i_bus_idle) begin
          state_d    = ST_SLEEP;
          clk_en_d   = 1'b0;
          sleeping_d = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (wk) begin
          sleeping_d = 1'b0;
          if (WAKE_DELAY == 0) begin
            state_d    = ST_RUN;
            clk_en_d   = 1'b1;
            wake_ack_d = 1'b1;
          end else begin
            state_d = ST_WAKE;
            cnt_d   = 8'(WAKE_DELAY);
          end
        end
      end
      ST_WAKE: begin
        // A dropped wakeup request does not abort; the settle always completes.
        if (cnt_q <= 8'd1) begin
          state_d    = ST_RUN;
          clk_en_d   = 1'b1;
          wake_ack_d = 1'b1;
        end
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      end
      default: begin
        state_d  = ST_RUN;
        clk_en_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RUN;
      clk_en_q   <= 1'b1;
      sleeping_q <= 1'b0;
      wake_ack_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      clk_en_q   <= clk_en_d;
      sleeping_q <= sleeping_d;
      wake_ack_q <= wake_ack_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pwr.o_clk_en   = clk_en_q;
  assign pwr.o_sleeping = sleeping_q;
  assign pwr.o_wake_ack = wake_ack_q;

`ifdef SERV_PWR_STATS_EN
  logic [31:0] sleep_cycles_q, sleep_cycles_d;

  always_comb begin
    sleep_cycles_d = sleep_cycles_q;
    if (pwr.i_stats_clr)  sleep_cycles_d = 32'd0;
    else if (!clk_en_q)   sleep_cycles_d = sleep_cycles_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sleep_cycles_q <= 32'd0;
    else          sleep_cycles_q <= sleep_cycles_d;
  end

  assign pwr.o_sleep_cycles = sleep_cycles_q;
`endif

endmodule
